// File: rtl/axis_stream_checker.sv
// Stream scoreboard: buffers a DUT stream and an expected stream in per-side FIFOs and compares them beat by beat.
// Optional first-mismatch capture ports are enabled with `define AXIS_CHECKER_FIRST_ERR_EN.

module axis_stream_checker_fifo #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [W-1:0]   data_i,
    input  logic [W/8-1:0] keep_i,
    input  logic           last_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           pop_i,
    output logic [W-1:0]   data_o,
    output logic [W/8-1:0] keep_o,
    output logic           last_o,
    output logic           empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]   data_mem [DEPTH];
    logic [W/8-1:0] keep_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;

    logic [AW:0] wr_q, wr_d, rd_q, rd_d, used_d;
    logic        ready_q;
    logic        push;

    assign push   = valid_i & ready_q;
    assign wr_d   = wr_q + (AW+1)'(push);
    assign rd_d   = rd_q + (AW+1)'(pop_i);
    assign used_d = wr_d - rd_d;

    // ready is registered from the post-update occupancy, so it is exactly !full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= (used_d != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q[AW-1:0]] <= data_i;
            keep_mem[wr_q[AW-1:0]] <= keep_i;
            last_mem[wr_q[AW-1:0]] <= last_i;
        end
    end

    assign ready_o = ready_q;
    assign empty_o = (wr_q == rd_q);
    assign data_o  = data_mem[rd_q[AW-1:0]];
    assign keep_o  = keep_mem[rd_q[AW-1:0]];
    assign last_o  = last_mem[rd_q[AW-1:0]];
endmodule

module axis_stream_checker #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PKT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PKT_W-1:0] n_pkts,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic [W-1:0]     s_dut_tdata,
    input  logic [W/8-1:0]   s_dut_tkeep,
    input  logic             s_dut_tlast,
    input  logic             s_dut_tvalid,
    output logic             s_dut_tready,
    input  logic [W-1:0]     s_exp_tdata,
    input  logic [W/8-1:0]   s_exp_tkeep,
    input  logic             s_exp_tlast,
    input  logic             s_exp_tvalid,
    output logic             s_exp_tready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [PKT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef AXIS_CHECKER_FIRST_ERR_EN
    ,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_beat,
    output logic [W-1:0]     first_err_dut,
    output logic [W-1:0]     first_err_exp
`endif
);
    localparam int unsigned NB = W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TOUT} state_e;

    state_e           state_q;
    logic             busy_q, done_q, pass_q, timeout_q;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [PKT_W-1:0] n_pkts_q;
    logic [CNT_W-1:0] tmo_q;

    logic [W-1:0]  dut_data, exp_data;
    logic [NB-1:0] dut_keep, exp_keep;
    logic          dut_last, exp_last, dut_empty, exp_empty;
    logic          cmp, mismatch;

    assign cmp = (state_q == ST_RUN) && !start && !dut_empty && !exp_empty;

    axis_stream_checker_fifo #(.W(W), .DEPTH(DEPTH)) u_dut_fifo (
        .clk(clk), .rstn(rstn),
        .data_i(s_dut_tdata), .keep_i(s_dut_tkeep), .last_i(s_dut_tlast),
        .valid_i(s_dut_tvalid), .ready_o(s_dut_tready),
        .pop_i(cmp),
        .data_o(dut_data), .keep_o(dut_keep), .last_o(dut_last), .empty_o(dut_empty)
    );

    axis_stream_checker_fifo #(.W(W), .DEPTH(DEPTH)) u_exp_fifo (
        .clk(clk), .rstn(rstn),
        .data_i(s_exp_tdata), .keep_i(s_exp_tkeep), .last_i(s_exp_tlast),
        .valid_i(s_exp_tvalid), .ready_o(s_exp_tready),
        .pop_i(cmp),
        .data_o(exp_data), .keep_o(exp_keep), .last_o(exp_last), .empty_o(exp_empty)
    );

    // Masked bytes are ignored for data, but the keep vectors themselves must still agree.
    always_comb begin
        mismatch = (dut_keep != exp_keep) || (dut_last != exp_last);
        for (int unsigned i = 0; i < NB; i++) begin
            if (exp_keep[i] && (dut_data[8*i +: 8] != exp_data[8*i +: 8])) begin
                mismatch = 1'b1;
            end
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        pkt_cnt_d  = pkt_cnt_q + PKT_W'(exp_last);
        err_cnt_d  = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        stall_d    = stall_q + CNT_W'(1);
    end

`ifdef AXIS_CHECKER_FIRST_ERR_EN
    logic             fe_valid_q;
    logic [CNT_W-1:0] fe_beat_q;
    logic [W-1:0]     fe_dut_q, fe_exp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fe_valid_q <= 1'b0;
            fe_beat_q  <= '0;
            fe_dut_q   <= '0;
            fe_exp_q   <= '0;
        end else if (start) begin
            fe_valid_q <= 1'b0;
            fe_beat_q  <= '0;
            fe_dut_q   <= '0;
            fe_exp_q   <= '0;
        end else if (cmp && mismatch && !fe_valid_q) begin
            fe_valid_q <= 1'b1;
            fe_beat_q  <= beat_cnt_q;
            fe_dut_q   <= dut_data;
            fe_exp_q   <= exp_data;
        end
    end

    assign first_err_valid = fe_valid_q;
    assign first_err_beat  = fe_beat_q;
    assign first_err_dut   = fe_dut_q;
    assign first_err_exp   = fe_exp_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            stall_q    <= '0;
            n_pkts_q   <= '0;
            tmo_q      <= '0;
        end else if (start) begin
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            stall_q    <= '0;
            n_pkts_q   <= n_pkts;
            tmo_q      <= timeout_cycles;
            timeout_q  <= 1'b0;
            if (n_pkts == '0) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
            end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
            end
        end else if (state_q == ST_RUN) begin
            // A compare clears the stall count, so a final compare always beats the timeout.
            if (cmp) begin
                beat_cnt_q <= beat_cnt_d;
                err_cnt_q  <= err_cnt_d;
                pkt_cnt_q  <= pkt_cnt_d;
                stall_q    <= '0;
                if (exp_last && (pkt_cnt_d == n_pkts_q)) begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_d == '0);
                end
            end else begin
                stall_q <= stall_d;
                if ((tmo_q != '0) && (stall_d == tmo_q)) begin
                    state_q   <= ST_TOUT;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    pass_q    <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_axis_stream_checker.sv
// Scoreboard bench for axis_stream_checker: expected end-of-run results are queued by the stimulus
// and popped by a monitor when done rises.

module tb_axis_stream_checker;
    localparam int unsigned W     = 128;
    localparam int unsigned NB    = W / 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PKT_W = 16;

    typedef struct {
        logic [W-1:0]  d;
        logic [NB-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [CNT_W-1:0] beat;
        logic [PKT_W-1:0] pkt;
        logic [CNT_W-1:0] err;
        logic             pass;
        logic             tmo;
        logic             fe_valid;
        logic [CNT_W-1:0] fe_beat;
        logic [W-1:0]     fe_dut;
        logic [W-1:0]     fe_exp;
    } res_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [PKT_W-1:0] n_pkts = '0;
    logic [CNT_W-1:0] timeout_cycles = '0;
    logic [W-1:0]     s_dut_tdata = '0;
    logic [NB-1:0]    s_dut_tkeep = '0;
    logic             s_dut_tlast = 1'b0;
    logic             s_dut_tvalid = 1'b0;
    logic             s_dut_tready;
    logic [W-1:0]     s_exp_tdata = '0;
    logic [NB-1:0]    s_exp_tkeep = '0;
    logic             s_exp_tlast = 1'b0;
    logic             s_exp_tvalid = 1'b0;
    logic             s_exp_tready;
    logic             busy, done, pass, timeout;
    logic [CNT_W-1:0] beat_cnt, err_cnt;
    logic [PKT_W-1:0] pkt_cnt;
`ifdef AXIS_CHECKER_FIRST_ERR_EN
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_beat;
    logic [W-1:0]     first_err_dut, first_err_exp;
`endif

    axis_stream_checker #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .PKT_W(PKT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .n_pkts(n_pkts), .timeout_cycles(timeout_cycles),
        .s_dut_tdata(s_dut_tdata), .s_dut_tkeep(s_dut_tkeep), .s_dut_tlast(s_dut_tlast),
        .s_dut_tvalid(s_dut_tvalid), .s_dut_tready(s_dut_tready),
        .s_exp_tdata(s_exp_tdata), .s_exp_tkeep(s_exp_tkeep), .s_exp_tlast(s_exp_tlast),
        .s_exp_tvalid(s_exp_tvalid), .s_exp_tready(s_exp_tready),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`ifdef AXIS_CHECKER_FIRST_ERR_EN
        ,
        .first_err_valid(first_err_valid), .first_err_beat(first_err_beat),
        .first_err_dut(first_err_dut), .first_err_exp(first_err_exp)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    beat_t       dut_beats[$];
    beat_t       exp_beats[$];
    res_t        sb_q[$];
    int unsigned exp_acc = 0;
    int unsigned cyc = 0;
    int unsigned last_beat_cyc = 0;
    int unsigned tmo_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expected result each time done rises.
    initial begin
        logic done_prev;
        res_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got done=1 want no result pending");
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_cnt", W'(beat_cnt), W'(e.beat));
                    chk("pkt_cnt", W'(pkt_cnt), W'(e.pkt));
                    chk("err_cnt", W'(err_cnt), W'(e.err));
                    chk("pass", W'(pass), W'(e.pass));
                    chk("timeout", W'(timeout), W'(e.tmo));
                    chk("busy_at_done", W'(busy), W'(0));
`ifdef AXIS_CHECKER_FIRST_ERR_EN
                    chk("first_err_valid", W'(first_err_valid), W'(e.fe_valid));
                    chk("first_err_beat", W'(first_err_beat), W'(e.fe_beat));
                    chk("first_err_dut", first_err_dut, e.fe_dut);
                    chk("first_err_exp", first_err_exp, e.fe_exp);
`endif
                end
            end
            done_prev = done;
        end
    end

    initial begin
        logic [CNT_W-1:0] beat_prev;
        logic tmo_prev;
        beat_prev = '0;
        tmo_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (beat_cnt != beat_prev) last_beat_cyc = cyc;
            if (timeout && !tmo_prev) tmo_rise_cyc = cyc;
            beat_prev = beat_cnt;
            tmo_prev = timeout;
        end
    end

    function automatic logic [W-1:0] mk_data(input int unsigned i);
        logic [31:0] w;
        w = 32'hC0DE0000 + i;
        return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'h01010101};
    endfunction

    task automatic build(input int unsigned npk, input int unsigned bpp);
        beat_t x;
        dut_beats.delete();
        exp_beats.delete();
        for (int unsigned p = 0; p < npk; p++) begin
            for (int unsigned b = 0; b < bpp; b++) begin
                x.d = mk_data(p * bpp + b);
                x.k = '1;
                x.l = (b == bpp - 1);
                dut_beats.push_back(x);
                exp_beats.push_back(x);
            end
        end
    endtask

    task automatic expect_res(input int unsigned b, input int unsigned p, input int unsigned e,
                              input logic ps, input logic tm, input logic fv, input int unsigned fb,
                              input logic [W-1:0] fd, input logic [W-1:0] fe);
        res_t r;
        r.beat = CNT_W'(b); r.pkt = PKT_W'(p); r.err = CNT_W'(e);
        r.pass = ps; r.tmo = tm; r.fe_valid = fv; r.fe_beat = CNT_W'(fb);
        r.fe_dut = fd; r.fe_exp = fe;
        sb_q.push_back(r);
    endtask

    task automatic drive(input bit is_dut, input int unsigned delay);
        beat_t b;
        int unsigned i, n, guard;
        bit rdy;
        n = is_dut ? dut_beats.size() : exp_beats.size();
        i = 0;
        guard = 0;
        repeat (delay) @(negedge clk);
        while (i < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            b = is_dut ? dut_beats[i] : exp_beats[i];
            if (is_dut) begin
                s_dut_tdata = b.d; s_dut_tkeep = b.k; s_dut_tlast = b.l; s_dut_tvalid = 1'b1;
                rdy = s_dut_tready;
            end else begin
                s_exp_tdata = b.d; s_exp_tkeep = b.k; s_exp_tlast = b.l; s_exp_tvalid = 1'b1;
                rdy = s_exp_tready;
            end
            if (rdy) i++;
            if (!is_dut) exp_acc = i;
        end
        @(negedge clk);
        if (is_dut) s_dut_tvalid = 1'b0;
        else s_exp_tvalid = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL drive_stalled side=%0d got %0d beats want %0d", is_dut, i, n);
        end
    endtask

    task automatic pulse_start(input int unsigned np, input int unsigned tmo);
        @(negedge clk);
        n_pkts = PKT_W'(np);
        timeout_cycles = CNT_W'(tmo);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned c;
        c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done got no done within %0d cycles want done", budget);
            sb_q.delete();
        end
    endtask

    task automatic run(input int unsigned np, input int unsigned tmo,
                       input int unsigned dd, input int unsigned ed);
        pulse_start(np, tmo);
        fork
            drive(1'b1, dd);
            drive(1'b0, ed);
        join
        wait_done(400);
    endtask

    initial begin
        logic [W-1:0] mask, dd;
        beat_t x;

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_beat", W'(beat_cnt), W'(0));
        chk("rst_dut_tready", W'(s_dut_tready), W'(0));
        chk("rst_exp_tready", W'(s_exp_tready), W'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_dut_tready", W'(s_dut_tready), W'(1));
        chk("rel_exp_tready", W'(s_exp_tready), W'(1));

        // n_pkts = 0 finishes at once with pass
        expect_res(0, 0, 0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        pulse_start(0, 0);
        wait_done(20);

        // identical streams, 2 packets of 4 beats
        build(2, 4);
        expect_res(8, 2, 0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        run(2, 0, 0, 0);

        // beat 5 differs in byte 3
        build(2, 4);
        mask = 128'hFF << 24;
        x = dut_beats[5];
        x.d = x.d ^ mask;
        dut_beats[5] = x;
        expect_res(8, 2, 1, 1'b0, 1'b0, 1'b1, 5, mk_data(5) ^ mask, mk_data(5));
        run(2, 0, 0, 3);

        // exp keep 0x00FF, garbage upper DUT half, equal keep: no mismatch
        build(1, 1);
        x = exp_beats[0]; x.k = 16'h00FF; exp_beats[0] = x;
        dd = mk_data(0);
        dd[127:64] = 64'hDEADBEEF_0BADF00D;
        x.d = dd; dut_beats[0] = x;
        expect_res(1, 1, 0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        run(1, 0, 0, 0);

        // same beat but DUT keep all ones: keep mismatch
        x = dut_beats[0]; x.k = 16'hFFFF; dut_beats[0] = x;
        expect_res(1, 1, 1, 1'b0, 1'b0, 1'b1, 0, dd, mk_data(0));
        run(1, 0, 0, 0);

        // DUT stream delayed 20 cycles: exp FIFO fills and back-pressures
        build(2, 4);
        expect_res(8, 2, 0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        pulse_start(2, 0);
        exp_acc = 0;
        fork
            drive(1'b1, 20);
            drive(1'b0, 0);
            begin
                repeat (12) @(negedge clk);
                chk("skew_exp_accepted", W'(exp_acc), W'(4));
                chk("skew_exp_tready", W'(s_exp_tready), W'(0));
                chk("skew_busy", W'(busy), W'(1));
            end
        join
        wait_done(400);

        // only one of two packets arrives: timeout 50 cycles after the last compare
        build(1, 2);
        expect_res(2, 1, 0, 1'b0, 1'b1, 1'b0, 0, '0, '0);
        run(2, 50, 0, 0);
        chk("tmo_latency", W'(tmo_rise_cyc - last_beat_cyc), W'(50));
        chk("tmo_done", W'(done), W'(1));

        // reset asserted mid-packet
        build(1, 4);
        pulse_start(1, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_dut_tdata = dut_beats[i].d; s_dut_tkeep = '1; s_dut_tlast = 1'b0; s_dut_tvalid = 1'b1;
            s_exp_tdata = exp_beats[i].d; s_exp_tkeep = '1; s_exp_tlast = 1'b0; s_exp_tvalid = 1'b1;
        end
        @(negedge clk);
        chk("pre_reset_beat", W'(beat_cnt), W'(1));
        rstn = 1'b0;
        s_dut_tvalid = 1'b0;
        s_exp_tvalid = 1'b0;
        #1;
        chk("async_rst_beat", W'(beat_cnt), W'(0));
        chk("async_rst_busy", W'(busy), W'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", W'({busy, done, pass, timeout}), W'(0));
        chk("post_rst_counts", W'({beat_cnt, pkt_cnt, err_cnt}), W'(0));
        chk("post_rst_treadys", W'({s_dut_tready, s_exp_tready}), W'(2'b11));

        build(1, 2);
        expect_res(2, 1, 0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        run(1, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 20000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
